// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-lite encodings, the command record and the alignment rule used by the master.
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HWORD = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } ahb3lite_cmd_t;

    // Only the two address LSBs matter; anything wider than a word is never legal here.
    function automatic logic ahb3lite_misaligned(input logic [1:0] addr, input logic [2:0] size);
        case (size)
            HSIZE_BYTE:  return 1'b0;
            HSIZE_HWORD: return addr[0];
            HSIZE_WORD:  return addr != 2'b00;
            default:     return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/ahb3lite_master.sv
// ahb3lite_master: single-transfer AHB3-lite initiator with valid/ready commands and in-order responses.
// Define AHB3LITE_MASTER_PIPELINE_EN to overlap the next address phase with the current data phase.
module ahb3lite_master
    import ahb3lite_pkg::*;
#(
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_WRITE,
    input  logic [31:0] CMD_ADDR,
    input  logic [2:0]  CMD_SIZE,
    input  logic [31:0] CMD_WDATA,
    output logic        RSP_VALID,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR,
    output logic        RSP_CANCEL,
    output logic [31:0] HADDR,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic [1:0]  HTRANS,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA,
    input  logic        HRESP
);

    logic          ap_v, dp_v, cancel_pend, dp_write;
    ahb3lite_cmd_t ap_cmd;
    logic [31:0]   hwdata_q;
    logic          rsp_valid_q, rsp_err_q, rsp_cancel_q;
    logic [31:0]   rsp_rdata_q;

    logic          ap_v_n, dp_v_n, cancel_pend_n, dp_write_n;
    ahb3lite_cmd_t ap_cmd_n, cmd_in;
    logic [31:0]   hwdata_n;
    logic          rsp_valid_n, rsp_err_n, rsp_cancel_n;
    logic [31:0]   rsp_rdata_n;

    logic misaligned, bus_idle, base_ready, accept, err_first, ap_done, dp_done;

    assign cmd_in     = '{write: CMD_WRITE, addr: CMD_ADDR, size: CMD_SIZE, wdata: CMD_WDATA};
    assign misaligned = ahb3lite_misaligned(CMD_ADDR[1:0], CMD_SIZE);
    assign bus_idle   = ~ap_v & ~dp_v & ~cancel_pend;

`ifdef AHB3LITE_MASTER_PIPELINE_EN
    assign base_ready = ~cancel_pend & (~ap_v | (HREADY & (HRESP == HRESP_OKAY)));
`else
    assign base_ready = bus_idle;
`endif

    // Misaligned commands never touch the bus, so they wait for a quiet bus to keep responses ordered.
    assign CMD_READY = ~RESET & base_ready & (~misaligned | bus_idle);
    assign accept    = CMD_VALID & CMD_READY;
    assign err_first = dp_v & ~HREADY & (HRESP == HRESP_ERROR);
    assign ap_done   = ap_v & HREADY;
    assign dp_done   = dp_v & HREADY;

    always_comb begin
        ap_v_n        = ap_v;
        ap_cmd_n      = ap_cmd;
        dp_v_n        = dp_v;
        dp_write_n    = dp_write;
        hwdata_n      = hwdata_q;
        cancel_pend_n = cancel_pend;
        rsp_valid_n   = 1'b0;
        rsp_err_n     = 1'b0;
        rsp_cancel_n  = 1'b0;
        rsp_rdata_n   = '0;

        if (dp_done) begin
            dp_v_n      = 1'b0;
            rsp_valid_n = 1'b1;
            rsp_err_n   = (HRESP == HRESP_ERROR);
            rsp_rdata_n = (~dp_write & (HRESP == HRESP_OKAY)) ? HRDATA : '0;
        end else if (cancel_pend & ~dp_v) begin
            cancel_pend_n = 1'b0;
            rsp_valid_n   = 1'b1;
            rsp_err_n     = 1'b1;
            rsp_cancel_n  = 1'b1;
        end else if (accept & misaligned) begin
            rsp_valid_n = 1'b1;
            rsp_err_n   = 1'b1;
        end

        // The first ERROR cycle withdraws a queued address phase instead of letting it complete.
        if (err_first) begin
            ap_v_n        = 1'b0;
            cancel_pend_n = cancel_pend | ap_v;
        end else if (ap_done) begin
            ap_v_n     = 1'b0;
            dp_v_n     = 1'b1;
            dp_write_n = ap_cmd.write;
            hwdata_n   = ap_cmd.wdata;
        end

        if (accept & ~misaligned) begin
            ap_v_n   = 1'b1;
            ap_cmd_n = cmd_in;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ap_v         <= 1'b0;
            ap_cmd       <= '0;
            dp_v         <= 1'b0;
            dp_write     <= 1'b0;
            hwdata_q     <= '0;
            cancel_pend  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_cancel_q <= 1'b0;
            rsp_rdata_q  <= '0;
        end else begin
            ap_v         <= ap_v_n;
            ap_cmd       <= ap_cmd_n;
            dp_v         <= dp_v_n;
            dp_write     <= dp_write_n;
            hwdata_q     <= hwdata_n;
            cancel_pend  <= cancel_pend_n;
            rsp_valid_q  <= rsp_valid_n;
            rsp_err_q    <= rsp_err_n;
            rsp_cancel_q <= rsp_cancel_n;
            rsp_rdata_q  <= rsp_rdata_n;
        end
    end

    assign HTRANS     = ap_v ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR      = ap_cmd.addr;
    assign HWRITE     = ap_cmd.write;
    assign HSIZE      = ap_cmd.size;
    assign HWDATA     = hwdata_q;
    assign HBURST     = HBURST_SINGLE;
    assign HPROT      = HPROT_VAL;
    assign HMASTLOCK  = 1'b0;
    assign RSP_VALID  = rsp_valid_q;
    assign RSP_RDATA  = rsp_rdata_q;
    assign RSP_ERR    = rsp_err_q;
    assign RSP_CANCEL = rsp_cancel_q;

endmodule

// File: tb/tb_ahb3lite_master.sv
// Bench for ahb3lite_master: directed timing scenarios and a randomized run against a memory-backed
// slave with an in-order response model.
`timescale 1ns/1ps
module tb_ahb3lite_master;
    import ahb3lite_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        CMD_VALID, CMD_READY, CMD_WRITE;
    logic [31:0] CMD_ADDR, CMD_WDATA;
    logic [2:0]  CMD_SIZE;
    logic        RSP_VALID, RSP_ERR, RSP_CANCEL;
    logic [31:0] RSP_RDATA;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic        HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    ahb3lite_master #(.HPROT_VAL(4'b0011)) dut (
        .CLK(CLK), .RESET(RESET),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_SIZE(CMD_SIZE), .CMD_WDATA(CMD_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR), .RSP_CANCEL(RSP_CANCEL),
        .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_cmd(input logic valid, input logic write, input logic [31:0] addr,
                           input logic [2:0] size, input logic [31:0] wdata);
        CMD_VALID = valid;
        CMD_WRITE = write;
        CMD_ADDR  = addr;
        CMD_SIZE  = size;
        CMD_WDATA = wdata;
    endtask

    task automatic test_reset();
        RESET = 1'b1; HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        set_cmd(1'b1, 1'b1, 32'h40, HSIZE_WORD, 32'h1);
        tick(); tick();
        vectors++;
        if ({HTRANS, HADDR, HWDATA, HSIZE, HWRITE, HBURST, HMASTLOCK, HPROT} !==
            {HTRANS_IDLE, 32'h0, 32'h0, 3'd0, 1'b0, HBURST_SINGLE, 1'b0, 4'b0011}) begin
            miscompares++;
            $display("[TB] FAIL reset_bus: got %h required %h",
                     {HTRANS, HADDR, HWDATA, HSIZE, HWRITE, HBURST, HMASTLOCK, HPROT},
                     {HTRANS_IDLE, 32'h0, 32'h0, 3'd0, 1'b0, HBURST_SINGLE, 1'b0, 4'b0011});
        end
        vectors++;
        if ({RSP_VALID, RSP_ERR, RSP_CANCEL, RSP_RDATA} !== 35'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_rsp: got %h required 0", {RSP_VALID, RSP_ERR, RSP_CANCEL, RSP_RDATA});
        end
        vectors++;
        if (CMD_READY !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_ready: got %b required 0", CMD_READY);
        end
        set_cmd(1'b0, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
        RESET = 1'b0;
        #1;
        vectors++;
        if (CMD_READY !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL ready_after_reset: got %b required 1", CMD_READY);
        end
    endtask

    task automatic test_write_zero_wait();
        tick();
        set_cmd(1'b1, 1'b1, 32'h4, HSIZE_WORD, 32'hCAFEF00D);
        tick();
        set_cmd(1'b0, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
        vectors++;
        if ({HTRANS, HADDR, HWRITE, HSIZE} !== {HTRANS_NONSEQ, 32'h4, 1'b1, HSIZE_WORD}) begin
            miscompares++;
            $display("[TB] FAIL wr_addr_phase: got %h required %h", {HTRANS, HADDR, HWRITE, HSIZE},
                     {HTRANS_NONSEQ, 32'h4, 1'b1, HSIZE_WORD});
        end
        tick();
        vectors++;
        if ({HTRANS, HWDATA, RSP_VALID} !== {HTRANS_IDLE, 32'hCAFEF00D, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL wr_data_phase: got %h required %h", {HTRANS, HWDATA, RSP_VALID},
                     {HTRANS_IDLE, 32'hCAFEF00D, 1'b0});
        end
        tick();
        vectors++;
        if ({RSP_VALID, RSP_ERR, RSP_CANCEL, RSP_RDATA} !== {3'b100, 32'h0}) begin
            miscompares++;
            $display("[TB] FAIL wr_rsp: got %h required %h", {RSP_VALID, RSP_ERR, RSP_CANCEL, RSP_RDATA}, {3'b100, 32'h0});
        end
        tick();
        vectors++;
        if (RSP_VALID !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL wr_rsp_pulse: got %b required 0", RSP_VALID);
        end
    endtask

    task automatic test_read_waited();
        set_cmd(1'b1, 1'b0, 32'h8, HSIZE_WORD, 32'h0);
        tick();
        set_cmd(1'b0, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
        tick();
        HREADY = 1'b0;
        HRDATA = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({HTRANS, HADDR, HWRITE, RSP_VALID} !== {HTRANS_IDLE, 32'h8, 1'b0, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL rd_wait_hold[%0d]: got %h required %h", i, {HTRANS, HADDR, HWRITE, RSP_VALID},
                         {HTRANS_IDLE, 32'h8, 1'b0, 1'b0});
            end
        end
        HREADY = 1'b1;
        HRDATA = 32'h12345678;
        tick();
        HRDATA = 32'h0;
        vectors++;
        if ({RSP_VALID, RSP_ERR, RSP_CANCEL, RSP_RDATA} !== {3'b100, 32'h12345678}) begin
            miscompares++;
            $display("[TB] FAIL rd_wait_rsp: got %h required %h", {RSP_VALID, RSP_ERR, RSP_CANCEL, RSP_RDATA},
                     {3'b100, 32'h12345678});
        end
        tick();
    endtask

    task automatic test_misaligned();
        set_cmd(1'b1, 1'b0, 32'h3, HSIZE_HWORD, 32'h0);
        tick();
        set_cmd(1'b0, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
        vectors++;
        if ({HTRANS, RSP_VALID, RSP_ERR, RSP_CANCEL, RSP_RDATA} !== {HTRANS_IDLE, 3'b110, 32'h0}) begin
            miscompares++;
            $display("[TB] FAIL misaligned_hword: got %h required %h",
                     {HTRANS, RSP_VALID, RSP_ERR, RSP_CANCEL, RSP_RDATA}, {HTRANS_IDLE, 3'b110, 32'h0});
        end
        set_cmd(1'b1, 1'b1, 32'h6, HSIZE_WORD, 32'h0);
        tick();
        set_cmd(1'b0, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
        vectors++;
        if ({HTRANS, RSP_VALID, RSP_ERR} !== {HTRANS_IDLE, 2'b11}) begin
            miscompares++;
            $display("[TB] FAIL misaligned_word: got %h required %h", {HTRANS, RSP_VALID, RSP_ERR}, {HTRANS_IDLE, 2'b11});
        end
        set_cmd(1'b1, 1'b0, 32'h7, HSIZE_BYTE, 32'h0);
        tick();
        set_cmd(1'b0, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
        vectors++;
        if ({HTRANS, HADDR, HSIZE, RSP_VALID} !== {HTRANS_NONSEQ, 32'h7, HSIZE_BYTE, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL aligned_byte: got %h required %h", {HTRANS, HADDR, HSIZE, RSP_VALID},
                     {HTRANS_NONSEQ, 32'h7, HSIZE_BYTE, 1'b0});
        end
        tick(); tick();
        vectors++;
        if ({RSP_VALID, RSP_ERR} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL aligned_byte_rsp: got %b required 10", {RSP_VALID, RSP_ERR});
        end
        tick();
    endtask

    task automatic test_reset_mid_transfer();
        int stray;
        set_cmd(1'b1, 1'b0, 32'hC, HSIZE_WORD, 32'h0);
        tick();
        set_cmd(1'b0, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
        tick();
        HREADY = 1'b0;
        tick();
        RESET = 1'b1;
        tick();
        vectors++;
        if ({HTRANS, RSP_VALID} !== {HTRANS_IDLE, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL reset_mid: got %h required %h", {HTRANS, RSP_VALID}, {HTRANS_IDLE, 1'b0});
        end
        RESET = 1'b0;
        HREADY = 1'b1;
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (RSP_VALID === 1'b1) stray++;
        end
        vectors++;
        if (stray != 0) begin
            miscompares++;
            $display("[TB] FAIL reset_lost_rsp: got %0d responses required 0", stray);
        end
        set_cmd(1'b1, 1'b1, 32'h10, HSIZE_WORD, 32'h55AA55AA);
        tick();
        set_cmd(1'b0, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
        tick();
        vectors++;
        if (HWDATA !== 32'h55AA55AA) begin
            miscompares++;
            $display("[TB] FAIL reset_then_write_data: got %h required 55aa55aa", HWDATA);
        end
        tick();
        vectors++;
        if ({RSP_VALID, RSP_ERR} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL reset_then_write_rsp: got %b required 10", {RSP_VALID, RSP_ERR});
        end
        tick();
    endtask

`ifdef AHB3LITE_MASTER_PIPELINE_EN
    task automatic test_back_to_back();
        int rsp_cnt;
        rsp_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            set_cmd(1'b1, 1'b1, 32'(4 * i), HSIZE_WORD, 32'hA0000000 + 32'(i));
            vectors++;
            if (CMD_READY !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL b2b_ready[%0d]: got %b required 1", i, CMD_READY);
            end
            tick();
            if (RSP_VALID === 1'b1 && RSP_ERR === 1'b0) rsp_cnt++;
            vectors++;
            if ({HTRANS, HADDR} !== {HTRANS_NONSEQ, 32'(4 * i)}) begin
                miscompares++;
                $display("[TB] FAIL b2b_nonseq[%0d]: got %h required %h", i, {HTRANS, HADDR}, {HTRANS_NONSEQ, 32'(4 * i)});
            end
            if (i > 0) begin
                vectors++;
                if (HWDATA !== 32'hA0000000 + 32'(i - 1)) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_hwdata[%0d]: got %h required %h", i, HWDATA, 32'hA0000000 + 32'(i - 1));
                end
            end
        end
        set_cmd(1'b0, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
        for (int c = 0; c < 4; c++) begin
            tick();
            if (RSP_VALID === 1'b1 && RSP_ERR === 1'b0) rsp_cnt++;
        end
        vectors++;
        if (rsp_cnt != 4) begin
            miscompares++;
            $display("[TB] FAIL b2b_rsp_count: got %0d required 4", rsp_cnt);
        end
    endtask

    task automatic test_pipeline_error();
        set_cmd(1'b1, 1'b0, 32'h20, HSIZE_WORD, 32'h0);
        tick();
        set_cmd(1'b1, 1'b0, 32'h24, HSIZE_WORD, 32'h0);
        tick();
        set_cmd(1'b0, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
        vectors++;
        if ({HTRANS, HADDR} !== {HTRANS_NONSEQ, 32'h24}) begin
            miscompares++;
            $display("[TB] FAIL err_queued: got %h required %h", {HTRANS, HADDR}, {HTRANS_NONSEQ, 32'h24});
        end
        HREADY = 1'b0; HRESP = 1'b1; HRDATA = 32'hBAD0BAD0;
        tick();
        vectors++;
        if ({HTRANS, RSP_VALID} !== {HTRANS_IDLE, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL err_cancel_idle: got %h required %h", {HTRANS, RSP_VALID}, {HTRANS_IDLE, 1'b0});
        end
        HREADY = 1'b1;
        tick();
        HRESP = 1'b0; HRDATA = 32'h0;
        vectors++;
        if ({RSP_VALID, RSP_ERR, RSP_CANCEL, RSP_RDATA} !== {3'b110, 32'h0}) begin
            miscompares++;
            $display("[TB] FAIL err_rsp: got %h required %h", {RSP_VALID, RSP_ERR, RSP_CANCEL, RSP_RDATA}, {3'b110, 32'h0});
        end
        tick();
        vectors++;
        if ({RSP_VALID, RSP_ERR, RSP_CANCEL, RSP_RDATA} !== {3'b111, 32'h0}) begin
            miscompares++;
            $display("[TB] FAIL cancel_rsp: got %h required %h", {RSP_VALID, RSP_ERR, RSP_CANCEL, RSP_RDATA}, {3'b111, 32'h0});
        end
        tick();
        vectors++;
        if ({RSP_VALID, CMD_READY, HTRANS} !== {2'b01, HTRANS_IDLE}) begin
            miscompares++;
            $display("[TB] FAIL err_recover: got %b required 0100", {RSP_VALID, CMD_READY, HTRANS});
        end
    endtask
`endif

    task automatic test_random();
        logic [31:0] model_mem [16];
        logic [31:0] slave_mem [16];
        logic [33:0] exp_q [$];
        int          n_cmds;
        int          aligned_issued;
        int          nonseq_seen;
        bit          done;
        n_cmds = 60; aligned_issued = 0; nonseq_seen = 0; done = 1'b0;
        for (int i = 0; i < 16; i++) begin
            model_mem[i] = $urandom;
            slave_mem[i] = model_mem[i];
        end
        HREADY = 1'b1; HRESP = 1'b0;
        fork
            begin
                for (int i = 0; i < n_cmds; i++) begin
                    logic        w, mis;
                    logic [31:0] a, d, r;
                    logic [2:0]  s;
                    int          g;
                    r = $urandom;
                    w = r[31];
                    d = $urandom;
                    if ($urandom_range(0, 5) == 0) begin
                        s = 3'($urandom_range(1, 7));
                        a = {24'h0, r[7:0]};
                        if (s == HSIZE_HWORD) a[0] = 1'b1;
                        if (s == HSIZE_WORD)  a[1:0] = 2'($urandom_range(1, 3));
                    end else begin
                        s = HSIZE_WORD;
                        a = {26'h0, r[3:0], 2'b00};
                    end
                    mis = (s > 3'd2) || ((a % (32'd1 << s)) != 0);
                    set_cmd(1'b1, w, a, s, d);
                    g = 0;
                    @(negedge CLK);
                    while (CMD_READY !== 1'b1 && g < 200) begin
                        @(negedge CLK);
                        g++;
                    end
                    vectors++;
                    if (CMD_READY !== 1'b1) begin
                        miscompares++;
                        $display("[TB] FAIL rand_accept[%0d]: CMD_READY got %b required 1 within 200 cycles", i, CMD_READY);
                        CMD_VALID = 1'b0;
                        break;
                    end
                    if (mis) exp_q.push_back({2'b01, 32'h0});
                    else begin
                        aligned_issued++;
                        if (w) begin
                            model_mem[a[5:2]] = d;
                            exp_q.push_back({2'b00, 32'h0});
                        end else exp_q.push_back({2'b00, model_mem[a[5:2]]});
                    end
                    @(posedge CLK);
                    #1;
                    CMD_VALID = 1'b0;
                    repeat ($urandom_range(0, 2)) tick();
                end
            end
            begin
                int          got, cyc;
                logic [33:0] e;
                got = 0; cyc = 0;
                while (got < n_cmds && cyc < 4000) begin
                    @(negedge CLK);
                    cyc++;
                    if (RSP_VALID === 1'b1) begin
                        got++;
                        vectors++;
                        if (exp_q.size() == 0) begin
                            miscompares++;
                            $display("[TB] FAIL rand_rsp_extra: got %h with no response outstanding",
                                     {RSP_CANCEL, RSP_ERR, RSP_RDATA});
                        end else begin
                            e = exp_q.pop_front();
                            if ({RSP_CANCEL, RSP_ERR, RSP_RDATA} !== e) begin
                                miscompares++;
                                $display("[TB] FAIL rand_rsp[%0d]: got %h required %h", got - 1,
                                         {RSP_CANCEL, RSP_ERR, RSP_RDATA}, e);
                            end
                        end
                    end
                end
                vectors++;
                if (got != n_cmds) begin
                    miscompares++;
                    $display("[TB] FAIL rand_rsp_count: got %0d responses required %0d", got, n_cmds);
                end
                done = 1'b1;
            end
            begin
                logic [1:0]  p_trans;
                logic [31:0] p_addr, p_wdata;
                logic        p_write, p_ready;
                bit          s_dp, s_wr;
                int          s_idx, waits;
                s_dp = 1'b0; s_wr = 1'b0; s_idx = 0; waits = 0;
                p_trans = HTRANS; p_addr = HADDR; p_write = HWRITE; p_wdata = HWDATA; p_ready = HREADY;
                while (!done) begin
                    tick();
                    if (s_dp && p_ready) begin
                        if (s_wr) slave_mem[s_idx] = p_wdata;
                        s_dp = 1'b0;
                    end
                    if (p_trans == HTRANS_NONSEQ && p_ready) begin
                        s_dp = 1'b1; s_wr = p_write; s_idx = int'(p_addr[5:2]);
                        waits = $urandom_range(0, 2);
                        nonseq_seen++;
                    end
                    if (s_dp && waits > 0) begin
                        HREADY = 1'b0; HRDATA = $urandom; waits--;
                    end else begin
                        HREADY = 1'b1;
                        HRDATA = (s_dp && !s_wr) ? slave_mem[s_idx] : $urandom;
                    end
                    p_trans = HTRANS; p_addr = HADDR; p_write = HWRITE; p_wdata = HWDATA; p_ready = HREADY;
                end
                HREADY = 1'b1;
            end
        join
        vectors++;
        if (nonseq_seen != aligned_issued) begin
            miscompares++;
            $display("[TB] FAIL rand_bus_transfers: got %0d required %0d", nonseq_seen, aligned_issued);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RESET = 1'b1; HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        set_cmd(1'b0, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
        test_reset();
        test_write_zero_wait();
        test_read_waited();
        test_misaligned();
        test_reset_mid_transfer();
`ifdef AHB3LITE_MASTER_PIPELINE_EN
        test_back_to_back();
        test_pipeline_error();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
